multu_seq: RTL and testbench

MULTU_SEQ -- requirements
Module: multu_seq

---
 rtl/multu_seq_if.sv | 31 +++
 rtl/multu_seq.sv | 117 +++++++++++
 tb/tb_multu_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multu_seq_if.sv
// multu_seq_if -- request/response bundle for the sequential multiplier.
// The Signed operand-mode line exists only when MULTU_SIGNED_EN is defined.
interface multu_seq_if;
   logic        Start;
   logic [31:0] DataA;
   logic [31:0] DataB;
`ifdef MULTU_SIGNED_EN
   logic        Signed;
`endif
   logic [63:0] MultuAns;
   logic        Busy;
   logic        Done;

   // Requester side: issues operands, observes result and status.
   modport master (
      output Start, DataA, DataB,
`ifdef MULTU_SIGNED_EN
      output Signed,
`endif
      input  MultuAns, Busy, Done
   );

   // Multiplier side: consumes operands, produces result and status.
   modport slave (
      input  Start, DataA, DataB,
`ifdef MULTU_SIGNED_EN
      input  Signed,
`endif
      output MultuAns, Busy, Done
   );
endinterface : multu_seq_if

// File: rtl/multu_seq.sv
// multu_seq -- 32x32 -> 64 radix-2 shift-add multiplier, 32 steps per product.
// IDLE -> RUN (32 steps) -> DONE (one-cycle Done pulse); Start is accepted
// in IDLE or DONE and ignored while RUN.
// Optional feature: define MULTU_SIGNED_EN to add the Signed input, which
// multiplies two's-complement magnitudes and negates the product when the
// operand signs differ.
module multu_seq (
   input  logic       Clk,
   input  logic       Reset,
   multu_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] a_q;      // multiplicand (magnitude)
   logic [31:0] b_q;      // multiplier, consumed LSB first
   logic [63:0] p_q;      // partial product, shifts right each step
   logic [4:0]  cnt_q;    // step counter, wraps 31 -> 0 on the last step
   logic [63:0] ans_q;    // published product

   logic [32:0] sum_d;
   logic [63:0] p_d;
   logic [63:0] ans_d;
   logic [31:0] a_in_d;
   logic [31:0] b_in_d;

`ifdef MULTU_SIGNED_EN
   logic neg_q;           // product must be negated at completion
   logic neg_in_d;

   // Convert operands to magnitudes and record the result sign at accept.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      a_in_d   = bus.DataA;
      b_in_d   = bus.DataB;
      neg_in_d = 1'b0;
      if (bus.Signed) begin
         if (bus.DataA[31]) a_in_d = -bus.DataA;
         if (bus.DataB[31]) b_in_d = -bus.DataB;
         neg_in_d = bus.DataA[31] ^ bus.DataB[31];
      end
   end
`else
   // Unsigned build: operands are taken as-is.
   always_comb begin
      a_in_d = bus.DataA;
      b_in_d = bus.DataB;
   end
`endif

   // One shift-add step: 33-bit add into the upper half keeps the carry,
   // which then shifts into bit 63 so no product bit is lost.
   always_comb begin
      sum_d = {1'b0, p_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
      p_d   = {sum_d, p_q[31:1]};
`ifdef MULTU_SIGNED_EN
      ans_d = neg_q ? -p_d : p_d;
`else
      ans_d = p_d;
`endif
   end

   // Control FSM and datapath registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         ans_q   <= '0;
`ifdef MULTU_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would chain the step updates.
         case (state_q)
            IDLE, DONE: begin
               if (bus.Start) begin
                  a_q     <= a_in_d;
                  b_q     <= b_in_d;
                  p_q     <= '0;
                  cnt_q   <= '0;
`ifdef MULTU_SIGNED_EN
                  neg_q   <= neg_in_d;
`endif
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               p_q   <= p_d;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  ans_q   <= ans_d;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.MultuAns = ans_q;
   assign bus.Busy     = (state_q == RUN);
   assign bus.Done     = (state_q == DONE);

endmodule : multu_seq

// File: tb/tb_multu_seq.sv
// tb_multu_seq -- self-checking bench for multu_seq; expected products come
// from plain 64-bit arithmetic on the operands.
module tb_multu_seq;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   multu_seq_if bus ();

   multu_seq dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product from the operand values.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
`ifdef MULTU_SIGNED_EN
      if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`endif
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Issue Start now (time = edge+1) and wait for Done; operands are
   // scrambled after the accepting edge. Returns cycles to Done, Busy
   // sample count, result, whether MultuAns moved while busy, and timeout.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int cycles, output int busy_cnt,
                        output logic [63:0] ans, output bit moved, output bit tmo);
      logic [63:0] held;
      held  = bus.MultuAns;
      moved = 1'b0;
      bus.Start = 1'b1;
      bus.DataA = a;
      bus.DataB = b;
`ifdef MULTU_SIGNED_EN
      bus.Signed = s;
`endif
      @(posedge clk); #1;
      bus.Start = 1'b0;
      bus.DataA = $urandom;
      bus.DataB = $urandom;
`ifdef MULTU_SIGNED_EN
      bus.Signed = ~s;
`endif
      cycles   = 0;
      busy_cnt = 0;
      while (bus.Done !== 1'b1 && cycles < 40) begin
         if (bus.Busy === 1'b1) busy_cnt++;
         if (bus.MultuAns !== held) moved = 1'b1;
         @(posedge clk); #1;
         cycles++;
      end
      tmo = (bus.Done !== 1'b1);
      ans = bus.MultuAns;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.Start = 1'b1;
      bus.DataA = 32'hDEAD_BEEF;
      bus.DataB = 32'h1234_5678;
`ifdef MULTU_SIGNED_EN
      bus.Signed = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MultuAns !== 64'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b ans=%h, want 0 0 0",
                  bus.Busy, bus.Done, bus.MultuAns);
      end
      bus.Start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_max_operands();
      int cyc, bcnt; logic [63:0] ans; bit mv, tmo;
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || cyc != 32) begin
         errors++; $display("FAIL max_latency: got %0d cycles, want 32", cyc);
      end
      checks++;
      if (bcnt != 32) begin
         errors++; $display("FAIL max_busy: busy %0d cycles, want 32", bcnt);
      end
      checks++;
      if (ans !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL max_result: got %h want fffffffe00000001", ans);
      end
      checks++;
      if (bus.Busy !== 1'b0 || mv) begin
         errors++; $display("FAIL max_hold: busy_at_done=%b moved_early=%b, want 0 0", bus.Busy, mv);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.MultuAns !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL max_done_pulse: done=%b ans=%h, want 0 and held", bus.Done, bus.MultuAns);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt; logic [63:0] ans; bit mv, tmo;
      do_op(32'h0001_0000, 32'h0001_0000, 1'b0, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || ans !== 64'h0000_0001_0000_0000) begin
         errors++; $display("FAIL b2b_first: got %h want 0000000100000000", ans);
      end
      // Start in the Done cycle.
      do_op(32'h0, 32'h0000_1234, 1'b0, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || cyc != 32 || ans !== 64'h0) begin
         errors++; $display("FAIL b2b_second: cycles=%0d ans=%h, want 32 and 0", cyc, ans);
      end
      checks++;
      if (mv) begin
         errors++; $display("FAIL b2b_hold: MultuAns changed before Done, want held");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_in_run();
      int done_cnt, done_at;
      logic [63:0] ans;
      bus.Start = 1'b1; bus.DataA = 32'd3; bus.DataB = 32'd5;
`ifdef MULTU_SIGNED_EN
      bus.Signed = 1'b0;
`endif
      @(posedge clk); #1;
      bus.Start = 1'b0;
      done_cnt = 0; done_at = -1; ans = '0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 10) begin bus.Start = 1'b1; bus.DataA = 32'd7; bus.DataB = 32'd7; end
         else bus.Start = 1'b0;
         @(posedge clk); #1;
         if (bus.Done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin done_at = c; ans = bus.MultuAns; end
         end
      end
      checks++;
      if (done_cnt != 1 || done_at != 32) begin
         errors++; $display("FAIL run_ignore_done: pulses=%0d at %0d, want 1 at 32", done_cnt, done_at);
      end
      checks++;
      if (ans !== 64'd15) begin
         errors++; $display("FAIL run_ignore_result: got %0d want 15", ans);
      end
   endtask

   task automatic test_reset_abort();
      int cyc, bcnt, seen; logic [63:0] ans; bit mv, tmo;
      bus.Start = 1'b1; bus.DataA = 32'd6; bus.DataB = 32'd7;
`ifdef MULTU_SIGNED_EN
      bus.Signed = 1'b0;
`endif
      @(posedge clk); #1;
      bus.Start = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MultuAns !== 64'h0) begin
         errors++;
         $display("FAIL abort_async: busy=%b done=%b ans=%h, want 0 0 0",
                  bus.Busy, bus.Done, bus.MultuAns);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.Done === 1'b1 || bus.Busy === 1'b1 || bus.MultuAns !== 64'h0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL abort_quiet: %0d cycles of activity after abort, want 0", seen);
      end
      // Release reset just before an edge; Start at that first edge must be taken.
      rst = 1'b1; #2; rst = 1'b0;
      do_op(32'd6, 32'd7, 1'b0, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || cyc != 32 || ans !== 64'd42) begin
         errors++; $display("FAIL abort_recover: cycles=%0d ans=%0d, want 32 and 42", cyc, ans);
      end
   endtask

   task automatic test_random();
      int cyc, bcnt; logic [63:0] ans, exp; bit mv, tmo;
      logic [31:0] a, b; logic s;
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom;
         if (i == 0) a = 32'h0;
         if (i == 1) b = 32'h8000_0000;
`ifdef MULTU_SIGNED_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         exp = ref_prod(a, b, s);
         do_op(a, b, s, cyc, bcnt, ans, mv, tmo);
         checks++;
         if (tmo || cyc != 32 || ans !== exp) begin
            errors++;
            $display("FAIL random_%0d: a=%h b=%h s=%b got %h (%0d cyc) want %h (32 cyc)",
                     i, a, b, s, ans, cyc, exp);
         end
         if (i % 3 == 0) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
   endtask

`ifdef MULTU_SIGNED_EN
   task automatic test_signed();
      int cyc, bcnt; logic [63:0] ans; bit mv, tmo;
      do_op(32'hFFFF_FFFF, 32'd1, 1'b1, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || cyc != 32 || ans !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++; $display("FAIL signed_neg1: got %h want ffffffffffffffff", ans);
      end
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || ans !== 64'h4000_0000_0000_0000) begin
         errors++; $display("FAIL signed_min: got %h want 4000000000000000", ans);
      end
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, cyc, bcnt, ans, mv, tmo);
      checks++;
      if (tmo || ans !== 64'h0000_0000_FFFF_FFFF) begin
         errors++; $display("FAIL signed_off: got %h want 00000000ffffffff", ans);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.Start = 1'b0;
      bus.DataA = '0;
      bus.DataB = '0;
`ifdef MULTU_SIGNED_EN
      bus.Signed = 1'b0;
`endif
      test_reset();
      test_max_operands();
      test_back_to_back();
      test_start_in_run();
      test_reset_abort();
      test_random();
`ifdef MULTU_SIGNED_EN
      test_signed();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_multu_seq
